// File: rtl/pe_job_scheduler_pkg.sv
// Shared definitions for the PE job scheduler: dispatch state encoding,
// NoC packet field offsets and a packet builder.
package pe_job_scheduler_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Widest packet the builder handles; callers truncate to their own total_width.
  localparam int PKT_MAX_W = 2048;
  typedef logic [PKT_MAX_W-1:0] pkt_max_t;

  localparam int X_LSB = 0;

  function automatic int Y_LSB(input int x_size);
    return X_LSB + x_size;
  endfunction

  function automatic int TAG_LSB(input int x_size, input int y_size);
    return Y_LSB(x_size) + y_size;
  endfunction

  function automatic int DATA_LSB(input int x_size, input int y_size, input int pck_num);
    return TAG_LSB(x_size, y_size) + pck_num;
  endfunction

  // Fields must already fit their widths; they are OR-ed into place.
  function automatic pkt_max_t build_packet(input int x_size, input int y_size,
                                            input int pck_num, input pkt_max_t x,
                                            input pkt_max_t y, input pkt_max_t tag,
                                            input pkt_max_t data);
    return (x << X_LSB) | (y << Y_LSB(x_size)) | (tag << TAG_LSB(x_size, y_size))
         | (data << DATA_LSB(x_size, y_size, pck_num));
  endfunction

endpackage

// File: rtl/pe_job_scheduler_rr_idle_pick.sv
// Combinational round-robin finder: lowest idle PE index at or after ptr_i,
// wrapping back to index 1. Index 0 is the scheduler's own node and never picked.
module pe_job_scheduler_rr_idle_pick
  import pe_job_scheduler_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  busy_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  logic [N-1:0] avail;

  assign avail = ~busy_i & {{(N-1){1'b1}}, 1'b0};

  // First pass finds the lowest idle index overall (the wrap case); the second
  // pass overrides it with the lowest idle index at or after the pointer.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = N - 1; i >= 1; i--) begin
      if (avail[i]) begin
        found_o = 1'b1;
        idx_o   = IW'(i);
      end
    end
    for (int i = N - 1; i >= 1; i--) begin
      if (avail[i] && (IW'(i) >= ptr_i)) idx_o = IW'(i);
    end
  end

endmodule

// File: rtl/pe_job_scheduler.sv
// Host-to-mesh job scheduler at node (0,0): dispatches each host word to an
// idle PE round-robin and returns PE results to the host in arrival order.
module pe_job_scheduler
  import pe_job_scheduler_pkg::*;
#(
  parameter int X           = 8,
  parameter int Y           = 8,
  parameter int pck_num     = 12,
  parameter int data_width  = 256,
  parameter int x_size      = $clog2(X),
  parameter int y_size      = $clog2(Y),
  parameter int total_width = x_size + y_size + pck_num + data_width
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid,
  input  logic [data_width-1:0]  i_data,
  output logic                   o_ready,
  output logic                   o_valid,
  output logic [data_width-1:0]  o_data,
  input  logic                   i_ready,
  output logic                   o_noc_valid,
  output logic [total_width-1:0] o_noc_data,
  input  logic                   i_noc_ready,
  input  logic                   i_noc_valid,
  input  logic [total_width-1:0] i_noc_data,
  output logic                   o_noc_ready,
  output logic [X*Y-1:0]         o_busy,
  output logic                   o_err
);

  localparam int N      = X * Y;
  localparam int IW     = x_size + y_size;
  localparam int SEQ_W  = pck_num - IW;
  localparam int TAG_LO = TAG_LSB(x_size, y_size);
  localparam int DAT_LO = DATA_LSB(x_size, y_size, pck_num);

  state_e                 state_q, state_d;
  logic [total_width-1:0] noc_data_q, noc_data_d;
  logic [N-1:0]           busy_q, busy_d, set_vec, clr_vec;
  logic [IW-1:0]          ptr_q, ptr_d;
  logic [SEQ_W-1:0]       seq_q, seq_d;
  logic                   valid_q, valid_d;
  logic [data_width-1:0]  data_q, data_d;
  logic                   err_q, err_d;

  logic [IW-1:0]          pick_idx;
  logic                   pick_found;
  logic                   ret_fire;
  logic [IW-1:0]          ret_idx;
  logic                   ret_known;
  logic [TAG_LO+SEQ_W-1:0] unused_ret_bits;

  pe_job_scheduler_rr_idle_pick #(.N(N), .IW(IW)) u_rr_idle_pick (
    .busy_i  (busy_q),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  assign ret_idx         = i_noc_data[TAG_LO +: IW];
  assign ret_known       = int'(ret_idx) < N;
  assign unused_ret_bits = {i_noc_data[TAG_LO+IW +: SEQ_W], i_noc_data[TAG_LO-1:0]};
  assign o_noc_ready     = !valid_q || i_ready;
  assign ret_fire        = i_noc_valid && o_noc_ready;

  always_comb begin
    state_d    = state_q;
    noc_data_d = noc_data_q;
    ptr_d      = ptr_q;
    seq_d      = seq_q;
    set_vec    = '0;
    o_ready    = 1'b0;
    unique case (state_q)
      IDLE: begin
        o_ready = pick_found;
        if (i_valid && pick_found) begin
          noc_data_d = total_width'(build_packet(x_size, y_size, pck_num,
                                                 PKT_MAX_W'(int'(pick_idx) % X),
                                                 PKT_MAX_W'(int'(pick_idx) / X),
                                                 PKT_MAX_W'({seq_q, pick_idx}),
                                                 PKT_MAX_W'(i_data)));
          set_vec[pick_idx] = 1'b1;
          seq_d   = seq_q + SEQ_W'(1);
          ptr_d   = (pick_idx == IW'(N - 1)) ? IW'(1) : pick_idx + IW'(1);
          state_d = SEND;
        end
      end
      SEND: if (i_noc_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Return path: a result from a PE with no outstanding job is still forwarded.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    err_d   = err_q;
    clr_vec = '0;
    if (ret_fire) begin
      valid_d = 1'b1;
      data_d  = i_noc_data[DAT_LO +: data_width];
      if (!ret_known || !busy_q[ret_idx]) err_d = 1'b1;
      if (ret_known) clr_vec[ret_idx] = 1'b1;
    end else if (i_ready) begin
      valid_d = 1'b0;
    end
    busy_d    = (busy_q & ~clr_vec) | set_vec;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      noc_data_q <= '0;
      busy_q     <= '0;
      ptr_q      <= IW'(1);
      seq_q      <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      noc_data_q <= noc_data_d;
      busy_q     <= busy_d;
      ptr_q      <= ptr_d;
      seq_q      <= seq_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      err_q      <= err_d;
    end
  end

  assign o_noc_valid = (state_q == SEND);
  assign o_noc_data  = noc_data_q;
  assign o_valid     = valid_q;
  assign o_data      = data_q;
  assign o_busy      = busy_q;
  assign o_err       = err_q;

endmodule
